// File: rtl/div_bcd_conv.sv
// div_bcd_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit
// per clock). It sits downstream of the iterative divider and turns the
// quotient or remainder into signed-magnitude BCD digits for the display.
//
// Handshake (valid/ready semantics): start is a request that is accepted only
// on a clk edge where the FSM is IDLE (busy = 0); a start seen while busy is
// dropped, not queued. Each accepted start produces exactly one done pulse
// (one cycle wide), and bcd/neg are updated on the same edge that raises done.
// They hold their value until the next done.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   start  - conversion request, sampled only in IDLE
//   sign   - 1: value is two's complement, 0: unsigned
//   value  - binary operand (width bits)
//   busy   - high while the FSM is in SHIFT or DONE
//   done   - one-cycle pulse, bcd/neg freshly valid
//   neg    - result is negative
//   bcd    - packed BCD, digit 0 in bits [3:0]
module div_bcd_conv #(
  parameter int width  = 6,
  parameter int digits = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sign,
  input  logic [width-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*digits-1:0]   bcd
);

  localparam int CW = $clog2(width) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [width-1:0]      mag;
  logic [4*digits-1:0]   scratch;
  logic [4*digits-1:0]   scratch_adj;
  logic [CW-1:0]         cnt;
  logic                  neg_pending;

  // Input-side sign handling: a negative two's-complement operand is
  // converted to its magnitude. The most-negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  logic                  in_neg;
  logic [width-1:0]      in_mag;

  assign in_neg = sign & value[width-1];
  assign in_mag = in_neg ? (~value + {{(width-1){1'b0}}, 1'b1}) : value;

  // Add-3 correction applied to every digit in parallel before the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < digits; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // busy follows the state register directly so that an asynchronous reset
  // drops it immediately.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mag         <= '0;
      scratch     <= '0;
      cnt         <= '0;
      neg_pending <= 1'b0;
      done        <= 1'b0;
      neg         <= 1'b0;
      bcd         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag         <= in_mag;
            neg_pending <= in_neg;
            scratch     <= '0;
            cnt         <= CW'(width);
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          // Magnitude MSB moves into scratch bit 0.
          {scratch, mag} <= {scratch_adj, mag} << 1;
          cnt            <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= scratch;
          neg   <= neg_pending;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_conv.sv
module tb_div_bcd_conv;

  localparam int W = 6;
  localparam int D = 2;
  localparam int LAT = W + 1;  // start edge to the edge that raises done

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           sign;
  logic [W-1:0]   value;
  logic           busy;
  logic           done;
  logic           neg;
  logic [4*D-1:0] bcd;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  div_bcd_conv #(.width(W), .digits(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sign  (sign),
    .value (value),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd)
  );

  // ---------------- scoreboard ----------------
  logic [4*D:0] exp_q[$];   // {neg, bcd}
  int           st_q[$];    // cycle number of the accepted start edge
  int           total = 0;
  int           bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain decimal arithmetic on the magnitude.
  function automatic logic [4*D:0] model(input logic [W-1:0] v, input logic s);
    int  m;
    logic n;
    logic [3:0] d0, d1;
    n  = s && v[W-1];
    m  = n ? ((1 << W) - int'(v)) : int'(v);
    d0 = 4'(m % 10);
    d1 = 4'(m / 10);
    return {n, d1, d0};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [4*D:0] e;
        int           sc;
        e  = exp_q.pop_front();
        sc = st_q.pop_front();
        check("bcd", int'(bcd), int'(e[4*D-1:0]));
        check("neg", int'(neg), int'(e[4*D]));
        check("latency", cyc - sc, LAT);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [W-1:0] v, input logic s, input bit expect_done);
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", guard, 0);
    value = v;
    sign  = s;
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back(model(v, s));
      st_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
    value = W'($urandom);
    sign  = 1'($urandom);
  endtask

  initial begin
    int n;
    int wait_cnt;
    reset = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bcd", int'(bcd), 0);
    check("rst_neg", int'(neg), 0);
    reset = 1'b0;
    @(negedge clk);

    // 63 unsigned, also measure busy length.
    issue(6'd63, 1'b0, 1'b1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, 7);

    issue(6'b100000, 1'b1, 1'b1);
    issue(6'b111111, 1'b1, 1'b1);
    issue(6'd0, 1'b1, 1'b1);
    issue(6'd9, 1'b0, 1'b1);
    issue(6'd10, 1'b0, 1'b1);

    // Start during SHIFT is ignored; next start lands on first IDLE edge.
    issue(6'd45, 1'b0, 1'b1);
    @(negedge clk);
    value = 6'd7;
    sign  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(6'd7, 1'b0, 1'b1);

    // Reset mid-conversion aborts with no done.
    issue(6'd50, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_bcd", int'(bcd), 0);
    check("abort_neg", int'(neg), 0);
    @(negedge clk);
    @(negedge clk);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    issue(6'd21, 1'b0, 1'b1);

    // Randomized conversions, back to back.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
